// File: rtl/fpu_issue_ctrl.sv
// FP issue/sequencing stage in front of the FP ALU: takes one request,
// drives operands plus one enable for the op's cycle count, captures the
// result and hands it to writeback.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake
//   in_op, in_a, in_b, in_tag request opcode, operands, destination tag
//   alu_a, alu_b, alu_en      ALU operand buses and one-hot enables
//   alu_result                ALU registered output
//   res_valid/res_ready       result handshake
//   res_data, res_tag         captured result and its tag
//   res_err                   illegal opcode flag (res_data = 0)
//   busy                      high whenever not IDLE
module fpu_issue_ctrl #(
  parameter int DIV_LAT  = 4,
  parameter int SQRT_LAT = 4,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [9:0]       alu_en,
  input  logic [31:0]      alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SQRT = 4'd4;
  localparam logic [3:0] OP_MAX  = 4'd9;

  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);
  localparam logic [3:0] SQRT_CNT = 4'(SQRT_LAT - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] op_q;
  logic [3:0] cnt;
  logic       accept;
  logic       legal;
  logic [3:0] cnt_load;

  assign accept = in_valid && in_ready;
  assign legal  = (in_op <= OP_MAX);

  always_comb begin
    cnt_load = 4'd0;
    if (in_op == OP_DIV) begin
      cnt_load = DIV_CNT;
    end else if (in_op == OP_SQRT) begin
      cnt_load = SQRT_CNT;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = legal ? EXEC : DONE;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_nx = CAPT;
        end
      end
      CAPT: state_nx = DONE;
      DONE: begin
        if (res_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    alu_en    = 10'd0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      EXEC: begin
        // Only legal ops reach EXEC, so the shift is always one-hot.
        alu_en = 10'b10_0000_0000 >> op_q;
      end
      CAPT: ;
      DONE: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      op_q     <= '0;
      cnt      <= '0;
      res_data <= '0;
      res_tag  <= '0;
      res_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= in_a;
            alu_b   <= in_b;
            op_q    <= in_op;
            res_tag <= in_tag;
            cnt     <= cnt_load;
            if (!legal) begin
              res_data <= '0;
              res_err  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        CAPT: begin
          res_data <= alu_result;
          res_err  <= 1'b0;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a table-driven ALU stand-in.
// Checks latency, enable shape, backpressure, illegal op, reset, throughput.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [9:0]  alu_en;
  logic [31:0] alu_result = 32'd0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_tag;
  logic        res_err;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .DIV_LAT(4),
    .SQRT_LAT(4),
    .TAG_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_a(in_a),
    .in_b(in_b),
    .in_tag(in_tag),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_en(alu_en),
    .alu_result(alu_result),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_tag(res_tag),
    .res_err(res_err),
    .busy(busy)
  );

  // ALU stand-in: known vectors only, anything else gives a marker value.
  function automatic logic [31:0] alu_f(input logic [9:0] en,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    r = 32'hDEAD0000 | {22'd0, en};
    if (en == 10'b1000000000) begin
      if (a == 32'h3F800000 && b == 32'h40000000) r = 32'h40400000;
      if (a == 32'h40000000 && b == 32'h40000000) r = 32'h40800000;
      if (a == 32'h3F800000 && b == 32'h3F800000) r = 32'h40000000;
      if (a == 32'h40400000 && b == 32'h3F800000) r = 32'h40800000;
    end
    if (en == 10'b0100000000 && a == 32'h40400000 && b == 32'h3F800000)
      r = 32'h40000000;
    if (en == 10'b0001000000 && a == 32'h40C00000 && b == 32'h40000000)
      r = 32'h40400000;
    if (en == 10'b0000100000 && a == 32'h41100000)
      r = 32'h40400000;
    if (en == 10'b0000000010 && a == 32'hBF800000 && b == 32'h3F800000)
      r = 32'h00000001;
    return r;
  endfunction

  always @(posedge clk) begin
    if (alu_en != 10'd0) alu_result <= alu_f(alu_en, alu_a, alu_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE and follow it to the DONE cycle.
  task automatic do_op(input string nm, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int lat_e,
                       input int en_e, input logic [31:0] d_e,
                       input logic err_e);
    int k;
    int ens;
    logic [9:0] en_x;
    en_x = (op <= 4'd9) ? (10'b1000000000 >> op) : 10'd0;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    step();
    in_valid = 1'b0;
    ens = 0;
    k = 1;
    while (!res_valid && k < 40) begin
      if (alu_en != 10'd0) begin
        ens++;
        chk({nm, " alu_en"}, 32'(alu_en), 32'(en_x));
        chk({nm, " alu_a"}, alu_a, a);
        chk({nm, " alu_b"}, alu_b, b);
      end
      step();
      k++;
    end
    chk({nm, " latency"}, 32'(k), 32'(lat_e));
    chk({nm, " en cycles"}, 32'(ens), 32'(en_e));
    chk({nm, " res_data"}, res_data, d_e);
    chk({nm, " res_tag"}, 32'(res_tag), 32'(tag));
    chk({nm, " res_err"}, 32'(res_err), 32'(err_e));
    chk({nm, " busy"}, 32'(busy), 32'd1);
    chk({nm, " alu_en done"}, 32'(alu_en), 32'd0);
  endtask

  logic [31:0] bb_a [3];
  logic [31:0] bb_b [3];
  logic [4:0]  bb_t [3];
  logic [31:0] bb_r [3];
  int          acc_t [3];

  initial begin
    int idx;
    int nres;
    int k;
    logic acc;
    logic got;

    rst = 1'b1;
    in_valid = 1'b0;
    in_op = 4'd0;
    in_a = 32'd0;
    in_b = 32'd0;
    in_tag = 5'd0;
    res_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst alu_en", 32'(alu_en), 32'd0);
    chk("rst res_data", res_data, 32'd0);
    chk("rst res_tag", 32'(res_tag), 32'd0);
    chk("rst res_err", 32'(res_err), 32'd0);
    chk("rst alu_a", alu_a, 32'd0);

    // Add, single-cycle
    do_op("add", 4'd0, 32'h3F800000, 32'h40000000, 5'd3,
          3, 1, 32'h40400000, 1'b0);
    step();
    chk("add res_valid drop", 32'(res_valid), 32'd0);
    chk("add in_ready back", 32'(in_ready), 32'd1);

    // Divide, four enable cycles
    do_op("div", 4'd3, 32'h40C00000, 32'h40000000, 5'd4,
          6, 4, 32'h40400000, 1'b0);
    step();
    chk("div in_ready back", 32'(in_ready), 32'd1);

    // Backpressure on a less-than compare
    res_ready = 1'b0;
    in_valid = 1'b1;
    in_op = 4'd8;
    in_a = 32'hBF800000;
    in_b = 32'h3F800000;
    in_tag = 5'd7;
    step();
    in_valid = 1'b0;
    k = 1;
    while (!res_valid && k < 40) begin
      step();
      k++;
    end
    chk("bp latency", 32'(k), 32'd3);
    in_valid = 1'b1;
    in_op = 4'd0;
    in_a = 32'h40000000;
    in_b = 32'h40000000;
    in_tag = 5'd9;
    for (int i = 0; i < 5; i++) begin
      chk("bp res_valid", 32'(res_valid), 32'd1);
      chk("bp res_data", res_data, 32'h00000001);
      chk("bp res_tag", 32'(res_tag), 32'd7);
      chk("bp in_ready", 32'(in_ready), 32'd0);
      chk("bp alu_a", alu_a, 32'hBF800000);
      step();
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp res_valid drop", 32'(res_valid), 32'd0);
    chk("bp in_ready back", 32'(in_ready), 32'd1);
    step();
    chk("bp 2nd not taken", 32'(busy), 32'd0);
    res_ready = 1'b1;

    // Illegal op, then a legal one clears the error
    do_op("illegal", 4'd12, 32'h12345678, 32'h9ABCDEF0, 5'd11,
          1, 0, 32'd0, 1'b1);
    step();
    do_op("sub", 4'd1, 32'h40400000, 32'h3F800000, 5'd12,
          3, 1, 32'h40000000, 1'b0);
    step();

    // Reset during the second sqrt EXEC cycle
    in_valid = 1'b1;
    in_op = 4'd4;
    in_a = 32'h41100000;
    in_b = 32'h0;
    in_tag = 5'd5;
    step();
    in_valid = 1'b0;
    chk("sqrt exec1 en", 32'(alu_en), 32'h20);
    step();
    chk("sqrt exec2 en", 32'(alu_en), 32'h20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid rst alu_en", 32'(alu_en), 32'd0);
    chk("mid rst in_ready", 32'(in_ready), 32'd1);
    chk("mid rst res_valid", 32'(res_valid), 32'd0);
    chk("mid rst res_data", res_data, 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst alu_a", alu_a, 32'd0);
    step();
    chk("mid rst stays idle", 32'(alu_en), 32'd0);
    do_op("add after rst", 4'd0, 32'h40400000, 32'h3F800000, 5'd6,
          3, 1, 32'h40800000, 1'b0);
    step();

    // Back-to-back adds with in_valid held high
    bb_a[0] = 32'h3F800000; bb_b[0] = 32'h40000000;
    bb_t[0] = 5'd1;         bb_r[0] = 32'h40400000;
    bb_a[1] = 32'h40000000; bb_b[1] = 32'h40000000;
    bb_t[1] = 5'd2;         bb_r[1] = 32'h40800000;
    bb_a[2] = 32'h3F800000; bb_b[2] = 32'h3F800000;
    bb_t[2] = 5'd30;        bb_r[2] = 32'h40000000;
    acc_t[0] = 0;
    acc_t[1] = 0;
    acc_t[2] = 0;
    idx = 0;
    nres = 0;
    res_ready = 1'b1;
    in_valid = 1'b1;
    in_op = 4'd0;
    in_a = bb_a[0];
    in_b = bb_b[0];
    in_tag = bb_t[0];
    for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      acc = in_valid && in_ready;
      got = res_valid && res_ready;
      if (got) begin
        chk("b2b res_data", res_data, bb_r[nres]);
        chk("b2b res_tag", 32'(res_tag), 32'(bb_t[nres]));
        nres++;
      end
      if (acc && idx < 3) acc_t[idx] = cyc;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_a = bb_a[idx];
          in_b = bb_b[idx];
          in_tag = bb_t[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("b2b results", 32'(nres), 32'd3);
    chk("b2b accepts", 32'(idx), 32'd3);
    chk("b2b gap 1", 32'(acc_t[1] - acc_t[0]), 32'd4);
    chk("b2b gap 2", 32'(acc_t[2] - acc_t[1]), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
